// File: rtl/nios_jtag_dbg_pkg.sv
// Shared types for the Nios II JTAG debug host: scan width default, IR codes, FSM states.
package nios_jtag_dbg_pkg;

    localparam int unsigned SR_WIDTH_DEF = 38;

    // Debug-module instruction register codes
    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_e;

    // Host sequencer states; UIR..RTI mirror the virtual-JTAG state strobes
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } state_e;

endpackage

// File: rtl/nios_jtag_tck_gen.sv
// tck generator: divides clk by 2*TCK_HALF while run is high, parks tck low otherwise.
//   clk, reset  : system clock, synchronous active-high reset
//   run         : enable; when low the divider clears and tck is forced low
//   tck         : registered JTAG clock
//   rise_c      : high in the clk cycle whose closing edge drives tck 0->1
//   fall_c      : high in the clk cycle whose closing edge drives tck 1->0
module nios_jtag_tck_gen #(
    parameter int unsigned TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned   DIV_W  = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(TCK_HALF - 1);

    logic [DIV_W-1:0] div_q;
    logic             tc_c;

    assign tc_c   = run && (div_q == DIV_TC);
    assign rise_c = tc_c && !tck;
    assign fall_c = tc_c && tck;

    // Divider and tck register
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_q <= '0;
            tck   <= 1'b0;
        end else if (tc_c) begin
            div_q <= '0;
            tck   <= ~tck;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/nios_jtag_debug_host.sv
// Host end of the Nios II debug-module virtual-JTAG link. Takes one command
// (IR + scan word), replays UIR -> CDR -> SDR xSR_WIDTH -> UDR -> RTI toward the
// target on a generated tck, and returns the word captured from tdo.
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : command handshake
//   rsp_valid/rsp_ready/rsp_data        : captured word, held until rsp_ready
//   busy                                : high whenever not IDLE
//   tck, tdi, tdo, ir_in                : target-side JTAG signals
//   vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti : virtual-state strobes
module nios_jtag_debug_host
    import nios_jtag_dbg_pkg::*;
#(
    parameter int unsigned SR_WIDTH = SR_WIDTH_DEF,
    parameter int unsigned TCK_HALF = 2,
    parameter int unsigned RTI_TCKS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [1:0]          ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int unsigned BIT_W = $clog2(SR_WIDTH + 1);
    localparam int unsigned RTI_W = $clog2(RTI_TCKS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);
    localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_TCKS - 1);

    state_e              state;
    logic [SR_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]    bit_cnt;
    logic [RTI_W-1:0]    rti_cnt;
    logic                run_c;
    logic                tck_rise_c;
    logic                tck_fall_c;

    // tck only runs while walking the virtual-JTAG states
    assign run_c = (state != ST_IDLE) && (state != ST_RESP);

    nios_jtag_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk    (clk),
        .reset  (reset),
        .run    (run_c),
        .tck    (tck),
        .rise_c (tck_rise_c),
        .fall_c (tck_fall_c)
    );

    // Sequencer, shifter and registered outputs; JTAG states advance on tck falls
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt        <= '0;
            rti_cnt        <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= 2'b00;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        ir_in     <= cmd_ir;
                        shift_q   <= cmd_data;
                        bit_cnt   <= '0;
                        rti_cnt   <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        vs_uir    <= 1'b1;
                        state     <= ST_UIR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_UIR: begin
                    if (tck_fall_c) begin
                        vs_uir <= 1'b0;
                        vs_cdr <= 1'b1;
                        state  <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (tck_fall_c) begin
                        vs_cdr <= 1'b0;
                        vs_sdr <= 1'b1;
                        tdi    <= shift_q[0];
                        state  <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    // Capture tdo on rise; present the next bit on fall
                    if (tck_rise_c) begin
                        shift_q <= {tdo, shift_q[SR_WIDTH-1:1]};
                    end
                    if (tck_fall_c) begin
                        if (bit_cnt == BIT_LAST) begin
                            vs_sdr <= 1'b0;
                            tdi    <= 1'b0;
                            vs_udr <= 1'b1;
                            state  <= ST_UDR;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tdi     <= shift_q[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_fall_c) begin
                        vs_udr         <= 1'b0;
                        jtag_state_rti <= 1'b1;
                        state          <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (tck_fall_c) begin
                        if (rti_cnt == RTI_LAST) begin
                            jtag_state_rti <= 1'b0;
                            state          <= ST_RESP;
                        end else begin
                            rti_cnt <= rti_cnt + RTI_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= shift_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
